cmp8_bist: RTL and testbench
============================

Name: cmp8_bist

Overview:
Built-in self-test sequencer for the 8-bit magnitude comparator. It is the stimulus and response side of the comparator's a/b → GREATER/LESSER interface. It sweeps every {a,b} pair exhaustively, samples the comparator's flags, checks them against a golden compare, and reports the pass/fail status, the error count and the first failing vector. It sits beside cmp8 in hardware, so the exhaustive check runs on silicon/FPGA instead of only in simulation.

Parameters:
WIDTH, 8, operand width; the sweep covers 2^(2*WIDTH) vectors.
SETTLE, 1, cycles each vector is held before the flags are sampled (must be ≥1).
ERRW, 16, width of the saturating error counter.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-high reset.
start  input  1  one-cycle pulse; begins a sweep from IDLE or DONE.
a  output  WIDTH  operand A to the comparator (upper half of the sweep vector).
b  output  WIDTH  operand B to the comparator (lower half of the sweep vector).
greater  input  1  comparator GREATER flag.
lesser  input  1  comparator LESSER flag.
busy  output  1  high while a sweep is running.
done  output  1  high in DONE until the next start.
pass  output  1  valid when done=1; high iff err_count==0.
err_count  output  ERRW  number of mismatches, saturating.
fail_valid  output  1  high once a first failure has been captured.
fail_a  output  WIDTH  a value of the first failing vector.
fail_b  output  WIDTH  b value of the first failing vector.

Behaviour:
- Reset (async, rst=1), all registers clear:
  - state=IDLE, vec=0, a=b=0.
  - busy=done=pass=0.
  - err_count=0, fail_valid=0, fail_a=fail_b=0.
- Reset mid-sweep aborts immediately. No results are retained.
- Sweep vector: vec is 2*WIDTH bits, with {a,b}=vec registered directly (a=vec[2W-1:W], b=vec[W-1:0]).
- FSM states: IDLE, DRIVE, SAMPLE, DONE.
- IDLE:
  - start=1 → clear vec, err_count, fail_valid, fail_a, fail_b.
  - Load settle counter with SETTLE-1, go to DRIVE.
- DRIVE:
  - a/b are stable.
  - Settle counter decrements each cycle; when it is 0, go to SAMPLE.
  - DRIVE lasts exactly SETTLE cycles.
- SAMPLE (one cycle):
  - exp_g=(a>b), exp_l=(a<b), both unsigned. The a==b case expects both flags low.
  - A mismatch occurs when greater≠exp_g or lesser≠exp_l.
  - On mismatch: err_count += 1, saturating at 2^ERRW-1.
  - On mismatch with fail_valid=0: capture fail_a=a, fail_b=b and set fail_valid=1. Later failures do not overwrite the capture.
  - If vec is all-ones, go to DONE (vec is not incremented, so there is no wrap).
  - Otherwise vec+=1, reload the settle counter, go to DRIVE.
- DONE:
  - done=1, pass=(err_count==0), busy=0.
  - a/b hold the last vector.
  - start → same clear/restart as from IDLE.
- busy=1 exactly in DRIVE and SAMPLE.
- start while busy is ignored.
- Timing:
  - Cycles per vector = SETTLE+1.
  - Total sweep = 2^(2W)*(SETTLE+1). Defaults: 131072 cycles from the start-edge transition into DRIVE to the last SAMPLE; done asserts on the following cycle.
- Flags are sampled synchronously in SAMPLE only. Flag values in DRIVE are don't-care.
- A simultaneous mismatch and saturated err_count keeps err_count at its maximum. fail capture is unaffected.

Decomposition:
- Package cmp8_bist_pkg holds:
  - state enum type bist_state_t {IDLE, DRIVE, SAMPLE, DONE};
  - default constants CMP_WIDTH=8 and ERR_WIDTH=16;
  - the golden-compare function returning {exp_g, exp_l}.
- One natural sub-module, bist_sweep_cnt:
  - a 2*WIDTH-bit vector counter with clear, increment and a terminal-count output;
  - the FSM in cmp8_bist drives it.

Test Plan:
- Correct cmp8 wired in, default params:
  - pulse start → busy=1 for 131072 cycles;
  - then done=1, pass=1, err_count=0, fail_valid=0, a=b=8'hFF.
- Faulty model with GREATER stuck at 0:
  - expected failures are every a>b case, 32640 in total;
  - err_count=32640, pass=0;
  - fail_a=8'h01, fail_b=8'h00 (first vector with a>b).
- Model with both flags inverted:
  - all 65536 vectors fail, so err_count saturates at 16'hFFFF;
  - fail_a=8'h00, fail_b=8'h00, pass=0.
- Reset mid-sweep:
  - assert rst when vec=16'h1234 → same-cycle async clear: busy=0, a=b=0, err_count=0;
  - a new start gives a full sweep with the correct result.
- start re-pulsed while busy → ignored; sweep length and results are unchanged.
- start re-pulsed in DONE → stats clear and done drops next cycle.
- SETTLE=3, WIDTH=2:
  - 16 vectors × 4 cycles = 64 cycles busy;
  - a/b are held for 3 cycles before each SAMPLE;
  - pass=1 with the correct model.

Source files
------------

// File: rtl/cmp8_bist_pkg.sv
// Shared types and the golden compare used by the cmp8 built-in self-test.
package cmp8_bist_pkg;

    typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} bist_state_t;

    localparam int unsigned CMP_WIDTH = 8;
    localparam int unsigned ERR_WIDTH = 16;

    // Returns {exp_greater, exp_lesser}; callers zero-extend narrower operands.
    function automatic logic [1:0] golden_cmp(input logic [31:0] op_a, input logic [31:0] op_b);
        return {op_a > op_b, op_a < op_b};
    endfunction

endpackage

// File: rtl/bist_sweep_cnt.sv
// Sweep vector counter: synchronous clear, increment, and all-ones terminal flag.
module bist_sweep_cnt #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] vec,
    output logic         last
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vec <= '0;
        end else if (clr) begin
            vec <= '0;
        end else if (inc) begin
            vec <= vec + W'(1);
        end
    end

    assign last = &vec;

endmodule

// File: rtl/cmp8_bist.sv
// Exhaustive self-test sequencer for the magnitude comparator: drives every {a,b}
// pair, checks GREATER/LESSER against a golden compare and records the results.
module cmp8_bist
    import cmp8_bist_pkg::*;
#(
    parameter int unsigned WIDTH  = CMP_WIDTH,
    parameter int unsigned SETTLE = 1,
    parameter int unsigned ERRW   = ERR_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    input  logic             greater,
    input  logic             lesser,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERRW-1:0]  err_count,
    output logic             fail_valid,
    output logic [WIDTH-1:0] fail_a,
    output logic [WIDTH-1:0] fail_b
);

    localparam int unsigned VW = 2 * WIDTH;
    localparam int unsigned SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE - 1);

    bist_state_t      state_q, state_d;
    logic [SW-1:0]    settle_q, settle_d;
    logic [ERRW-1:0]  err_q, err_d;
    logic             fv_q, fv_d;
    logic [WIDTH-1:0] fa_q, fa_d;
    logic [WIDTH-1:0] fb_q, fb_d;

    logic          vec_clr, vec_inc, vec_last;
    logic [VW-1:0] vec;
    logic [1:0]    expected;
    logic          mismatch;

    bist_sweep_cnt #(
        .W(VW)
    ) u_sweep_cnt (
        .clk (clk),
        .rst (rst),
        .clr (vec_clr),
        .inc (vec_inc),
        .vec (vec),
        .last(vec_last)
    );

    assign a = vec[VW-1:WIDTH];
    assign b = vec[WIDTH-1:0];

    assign expected = golden_cmp(32'(a), 32'(b));
    assign mismatch = (greater != expected[1]) || (lesser != expected[0]);

    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        err_d    = err_q;
        fv_d     = fv_q;
        fa_d     = fa_q;
        fb_d     = fb_q;
        vec_clr  = 1'b0;
        vec_inc  = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    vec_clr  = 1'b1;
                    err_d    = '0;
                    fv_d     = 1'b0;
                    fa_d     = '0;
                    fb_d     = '0;
                    settle_d = SETTLE_LOAD;
                    state_d  = DRIVE;
                end
            end
            DRIVE: begin
                if (settle_q == '0) begin
                    state_d = SAMPLE;
                end else begin
                    settle_d = settle_q - SW'(1);
                end
            end
            SAMPLE: begin
                if (mismatch) begin
                    if (err_q != '1) begin
                        err_d = err_q + ERRW'(1);
                    end
                    // Only the first failing vector is kept.
                    if (!fv_q) begin
                        fv_d = 1'b1;
                        fa_d = a;
                        fb_d = b;
                    end
                end
                if (vec_last) begin
                    state_d = DONE;
                end else begin
                    vec_inc  = 1'b1;
                    settle_d = SETTLE_LOAD;
                    state_d  = DRIVE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            settle_q <= '0;
            err_q    <= '0;
            fv_q     <= 1'b0;
            fa_q     <= '0;
            fb_q     <= '0;
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
            err_q    <= err_d;
            fv_q     <= fv_d;
            fa_q     <= fa_d;
            fb_q     <= fb_d;
        end
    end

    assign busy       = (state_q == DRIVE) || (state_q == SAMPLE);
    assign done       = (state_q == DONE);
    assign pass       = done && (err_q == '0);
    assign err_count  = err_q;
    assign fail_valid = fv_q;
    assign fail_a     = fa_q;
    assign fail_b     = fb_q;

endmodule

// File: tb/tb_cmp8_bist.sv
// Directed bench for cmp8_bist: a reduced-width instance against correct and faulty
// comparator models, plus a WIDTH=2/SETTLE=3 instance for settle timing.
module tb_cmp8_bist;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic start_s;
    int   n_vec = 0;
    int   n_err = 0;
    int   mode  = 0;

    always #5 clk = ~clk;

    // Main DUT: WIDTH=4, SETTLE=1, ERRW=8 (256 vectors, 512 busy cycles).
    logic [3:0] a, b, fail_a, fail_b;
    logic [7:0] err_count;
    logic       greater, lesser, busy, done, pass, fail_valid;

    // Comparator models: 0 correct, 1 GREATER stuck at 0, 2 both flags inverted.
    always_comb begin
        case (mode)
            0:       begin greater = (a > b);  lesser = (a < b);  end
            1:       begin greater = 1'b0;     lesser = (a < b);  end
            default: begin greater = !(a > b); lesser = !(a < b); end
        endcase
    end

    cmp8_bist #(
        .WIDTH (4),
        .SETTLE(1),
        .ERRW  (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .a         (a),
        .b         (b),
        .greater   (greater),
        .lesser    (lesser),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .err_count (err_count),
        .fail_valid(fail_valid),
        .fail_a    (fail_a),
        .fail_b    (fail_b)
    );

    logic [1:0]  a_s, b_s, fail_a_s, fail_b_s;
    logic [15:0] err_count_s;
    logic        busy_s, done_s, pass_s, fail_valid_s;

    cmp8_bist #(
        .WIDTH (2),
        .SETTLE(3),
        .ERRW  (16)
    ) dut_s (
        .clk       (clk),
        .rst       (rst),
        .start     (start_s),
        .a         (a_s),
        .b         (b_s),
        .greater   (a_s > b_s),
        .lesser    (a_s < b_s),
        .busy      (busy_s),
        .done      (done_s),
        .pass      (pass_s),
        .err_count (err_count_s),
        .fail_valid(fail_valid_s),
        .fail_a    (fail_a_s),
        .fail_b    (fail_b_s)
    );

    // Pulses start, counts busy cycles and checks {a,b} steps once per 2 cycles.
    task automatic run_dut(input int repulse_at, output int cycles, output int order_err);
        cycles    = 0;
        order_err = 0;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        while (busy && cycles < 2000) begin
            if ({a, b} !== 8'(cycles / 2)) order_err++;
            cycles++;
            start = (cycles == repulse_at) || (cycles == repulse_at + 1);
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; start_s = 1'b0;
        @(negedge clk);
        n_vec++;
        if ({busy, done, pass, fail_valid, a, b, err_count, fail_a, fail_b} !== '0) begin
            n_err++;
            $display("FAIL reset_dut: got %h required 0",
                     {busy, done, pass, fail_valid, a, b, err_count, fail_a, fail_b});
        end
        n_vec++;
        if ({busy_s, done_s, a_s, b_s, err_count_s, fail_valid_s} !== '0) begin
            n_err++;
            $display("FAIL reset_small: got %h required 0",
                     {busy_s, done_s, a_s, b_s, err_count_s, fail_valid_s});
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_correct();
        int cyc, oe;
        mode = 0;
        run_dut(0, cyc, oe);
        n_vec++; if (cyc !== 512) begin n_err++;
            $display("FAIL correct_busy_cycles: got %0d required 512", cyc); end
        n_vec++; if (oe !== 0) begin n_err++;
            $display("FAIL correct_vec_order: got %0d bad steps required 0", oe); end
        n_vec++; if ({done, pass, busy, fail_valid} !== 4'b1100) begin n_err++;
            $display("FAIL correct_flags: done/pass/busy/fv got %b required 1100",
                     {done, pass, busy, fail_valid}); end
        n_vec++; if (err_count !== 8'd0) begin n_err++;
            $display("FAIL correct_err_count: got %0d required 0", err_count); end
        n_vec++; if ({a, b} !== 8'hFF) begin n_err++;
            $display("FAIL correct_last_vec: got %h required ff", {a, b}); end
    endtask

    task automatic test_stuck_greater();
        int cyc, oe;
        mode = 1;
        run_dut(0, cyc, oe);
        n_vec++; if (err_count !== 8'd120) begin n_err++;
            $display("FAIL stuck_err_count: got %0d required 120", err_count); end
        n_vec++; if ({done, pass, fail_valid} !== 3'b101) begin n_err++;
            $display("FAIL stuck_flags: done/pass/fv got %b required 101",
                     {done, pass, fail_valid}); end
        n_vec++; if ({fail_a, fail_b} !== 8'h10) begin n_err++;
            $display("FAIL stuck_first_fail: got %h required 10", {fail_a, fail_b}); end
    endtask

    task automatic test_restart_in_done();
        int t;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        n_vec++;
        if ({done, busy, fail_valid, err_count, fail_a, fail_b, a, b} !== {3'b010, 24'h0}) begin
            n_err++;
            $display("FAIL restart_clear: got %h required %h",
                     {done, busy, fail_valid, err_count, fail_a, fail_b, a, b}, {3'b010, 24'h0});
        end
        t = 0;
        while (busy && t < 2000) begin @(negedge clk); t++; end
        n_vec++; if ({done, err_count} !== {1'b1, 8'd120}) begin n_err++;
            $display("FAIL restart_result: done/err got %h required 178", {done, err_count}); end
    endtask

    task automatic test_inverted();
        int cyc, oe;
        mode = 2;
        run_dut(0, cyc, oe);
        n_vec++; if (err_count !== 8'hFF) begin n_err++;
            $display("FAIL inverted_saturate: got %h required ff", err_count); end
        n_vec++; if ({pass, fail_valid, fail_a, fail_b} !== {2'b01, 8'h00}) begin n_err++;
            $display("FAIL inverted_capture: got %h required 100",
                     {pass, fail_valid, fail_a, fail_b}); end
    endtask

    task automatic test_reset_mid_sweep();
        int t, cyc, oe;
        mode = 1;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        t = 0;
        while ({a, b} !== 8'h34 && t < 2000) begin @(negedge clk); t++; end
        n_vec++; if ({a, b} !== 8'h34) begin n_err++;
            $display("FAIL midreset_reach: got %h required 34", {a, b}); end
        n_vec++; if (err_count !== 8'd6) begin n_err++;
            $display("FAIL midreset_partial_err: got %0d required 6", err_count); end
        rst = 1'b1;
        #1;
        n_vec++;
        if ({busy, a, b, err_count, fail_valid} !== '0) begin n_err++;
            $display("FAIL midreset_clear: got %h required 0", {busy, a, b, err_count, fail_valid});
        end
        @(negedge clk) rst = 1'b0;
        mode = 0;
        run_dut(0, cyc, oe);
        n_vec++; if ({cyc, pass, err_count} !== {32'd512, 1'b1, 8'd0}) begin n_err++;
            $display("FAIL midreset_resweep: cycles %0d pass %b err %0d required 512 1 0",
                     cyc, pass, err_count); end
    endtask

    task automatic test_start_while_busy();
        int cyc, oe;
        mode = 1;
        run_dut(100, cyc, oe);
        n_vec++; if (cyc !== 512 || oe !== 0) begin n_err++;
            $display("FAIL busy_start_len: cycles %0d bad steps %0d required 512 0", cyc, oe); end
        n_vec++; if ({err_count, fail_a, fail_b, done} !== {8'd120, 8'h10, 1'b1}) begin n_err++;
            $display("FAIL busy_start_result: err %0d fail %h done %b required 120 10 1",
                     err_count, {fail_a, fail_b}, done); end
    endtask

    task automatic test_settle3();
        int cyc, oe;
        cyc = 0;
        oe  = 0;
        @(negedge clk) start_s = 1'b1;
        @(negedge clk) start_s = 1'b0;
        while (busy_s && cyc < 500) begin
            // Each vector spans 3 DRIVE cycles plus one SAMPLE.
            if ({a_s, b_s} !== 4'(cyc / 4)) oe++;
            cyc++;
            @(negedge clk);
        end
        n_vec++; if (cyc !== 64) begin n_err++;
            $display("FAIL settle3_busy_cycles: got %0d required 64", cyc); end
        n_vec++; if (oe !== 0) begin n_err++;
            $display("FAIL settle3_hold: got %0d bad cycles required 0", oe); end
        n_vec++; if ({done_s, pass_s, err_count_s, fail_valid_s, a_s, b_s} !== {2'b11, 17'h0, 4'hF})
        begin n_err++;
            $display("FAIL settle3_result: got %h required %h",
                     {done_s, pass_s, err_count_s, fail_valid_s, a_s, b_s}, {2'b11, 17'h0, 4'hF});
        end
    endtask

    initial begin
        test_reset();
        test_correct();
        test_stuck_greater();
        test_restart_in_done();
        test_inverted();
        test_reset_mid_sweep();
        test_start_while_busy();
        test_settle3();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
